// File: rtl/rv_pkg.sv
// Shared RV32I pipeline definitions: canonical NOP, major opcodes and the
// fetch-stage FSM encoding.
package rv_pkg;

    localparam int          XLEN_DEF  = 32;
    localparam logic [31:0] RV_NOP    = 32'h0000_0013;   // addi x0, x0, 0

    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_JAL    = 7'b1101111;
    localparam logic [6:0]  OP_JALR   = 7'b1100111;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buffer.sv
// Skid register for the instruction word that arrives while decode is stalled;
// while it holds a word, dout shows it instead of the live memory data.
module fetch_hold_buffer #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_capture,
    input  logic         i_release,
    input  logic         i_flush,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_dout
);

    logic [W-1:0] r_hold;
    logic         r_vld;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_hold <= '0;
            r_vld  <= 1'b0;
        end else if (i_flush || i_release) begin
            r_vld  <= 1'b0;
        end else if (i_capture) begin
            r_hold <= i_din;
            r_vld  <= 1'b1;
        end
    end

    assign o_dout = r_vld ? r_hold : i_din;

endmodule

// File: rtl/fetch_stage.sv
// IF stage plus IF/ID register: PC generation, synchronous imem read,
// stall hold and E-stage redirects.
module fetch_stage
    import rv_pkg::*;
#(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  PC_RESET = '0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_fetch_stall,
    input  logic            i_redirect_valid,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic [XLEN-1:0] o_imem_addr,
    output logic            o_imem_rd_en,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_pc_d,
    output logic [XLEN-1:0] o_pc_plus4_d,
    output logic [XLEN-1:0] o_inst_d,
    output logic            o_valid_d
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc_f;
    logic [XLEN-1:0] r_pc_d;
    logic            r_valid_d;

    logic            w_capture;
    logic            w_release;
    logic [XLEN-1:0] w_hold_dout;

    // Capture only on STALL entry; the re-read during the stall is for the
    // next instruction, not the one sitting in decode.
    assign w_capture = (r_state == RUN)   &&  i_fetch_stall && !i_redirect_valid;
    assign w_release = (r_state == STALL) && !i_fetch_stall && !i_redirect_valid;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state   <= BOOT;
            r_pc_f    <= PC_RESET;
            r_pc_d    <= '0;
            r_valid_d <= 1'b0;
        end else if (i_redirect_valid) begin
            r_state   <= RUN;
            r_pc_f    <= {i_redirect_pc[XLEN-1:2], 2'b00};
            r_valid_d <= 1'b0;
        end else if (i_fetch_stall) begin
            if (r_state == RUN)
                r_state <= STALL;
        end else begin
            r_state   <= RUN;
            r_pc_f    <= r_pc_f + XLEN'(4);
            r_pc_d    <= r_pc_f;
            r_valid_d <= 1'b1;
        end
    end

    fetch_hold_buffer #(.W(XLEN)) u_hold (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_capture (w_capture),
        .i_release (w_release),
        .i_flush   (i_redirect_valid),
        .i_din     (i_imem_rdata),
        .o_dout    (w_hold_dout)
    );

    assign o_imem_addr  = r_pc_f;
    assign o_imem_rd_en = i_reset;
    assign o_pc_d       = r_pc_d;
    assign o_pc_plus4_d = r_pc_d + XLEN'(4);
    assign o_valid_d    = r_valid_d;
    assign o_inst_d     = r_valid_d ? w_hold_dout : RV_NOP;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 1-cycle synchronous imem model;
// memory word at address a is a ^ 32'h1234_0000, except 0x108 = DEAD_BEEF.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic        imem_rd_en;
    logic [31:0] imem_rdata;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic [31:0] inst_d;
    logic        valid_d;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(32), .PC_RESET(32'h0000_0100)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_fetch_stall    (fetch_stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_pc    (redirect_pc),
        .o_imem_addr      (imem_addr),
        .o_imem_rd_en     (imem_rd_en),
        .i_imem_rdata     (imem_rdata),
        .o_pc_d           (pc_d),
        .o_pc_plus4_d     (pc_plus4_d),
        .o_inst_d         (inst_d),
        .o_valid_d        (valid_d)
    );

    always @(posedge clk)
        if (imem_rd_en)
            imem_rdata <= (imem_addr == 32'h108) ? 32'hDEAD_BEEF : (imem_addr ^ 32'h1234_0000);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0; fetch_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_rdata = '0;
        // T1 reset / boot
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(valid_d), 0);
        chk("rst_pc_d", pc_d, 0);
        chk("rst_rden", 32'(imem_rd_en), 0);
        chk("rst_inst", inst_d, NOP);
        reset = 1'b1;
        #1;
        chk("c0_addr", imem_addr, 32'h100);
        chk("c0_valid", 32'(valid_d), 0);
        chk("c0_rden", 32'(imem_rd_en), 1);
        @(negedge clk);
        chk("c1_addr", imem_addr, 32'h104);
        chk("c1_pc_d", pc_d, 32'h100);
        chk("c1_valid", 32'(valid_d), 1);
        chk("c1_inst", inst_d, 32'h1234_0100);
        chk("c1_pc4", pc_plus4_d, 32'h104);
        @(negedge clk);
        chk("c2_addr", imem_addr, 32'h108);
        chk("c2_inst", inst_d, 32'h1234_0104);
        // T2 stall hold with pc_d=108
        @(negedge clk);
        chk("c3_pc_d", pc_d, 32'h108);
        chk("c3_inst", inst_d, 32'hDEAD_BEEF);
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("stl%0d_pc_d", i), pc_d, 32'h108);
            chk($sformatf("stl%0d_inst", i), inst_d, 32'hDEAD_BEEF);
            chk($sformatf("stl%0d_addr", i), imem_addr, 32'h10C);
            chk($sformatf("stl%0d_valid", i), 32'(valid_d), 1);
        end
        fetch_stall = 1'b0;
        #1;
        chk("rel_inst", inst_d, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("post_pc_d", pc_d, 32'h10C);
        chk("post_inst", inst_d, 32'h1234_010C);
        chk("post_addr", imem_addr, 32'h110);
        // T3 redirect
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("rd1_valid", 32'(valid_d), 0);
        chk("rd1_addr", imem_addr, 32'h200);
        chk("rd1_inst", inst_d, NOP);
        @(negedge clk);
        chk("rd2_pc_d", pc_d, 32'h200);
        chk("rd2_valid", 32'(valid_d), 1);
        chk("rd2_pc4", pc_plus4_d, 32'h204);
        chk("rd2_inst", inst_d, 32'h1234_0200);
        // T4 redirect while in STALL
        fetch_stall = 1'b1;
        @(negedge clk);
        chk("t4_hold_inst", inst_d, 32'h1234_0200);
        chk("t4_hold_addr", imem_addr, 32'h204);
        redirect_valid = 1'b1; redirect_pc = 32'h303;
        @(negedge clk);
        redirect_valid = 1'b0; fetch_stall = 1'b0;
        chk("t4_addr", imem_addr, 32'h300);
        chk("t4_valid", 32'(valid_d), 0);
        chk("t4_inst", inst_d, NOP);
        @(negedge clk);
        chk("t4b_pc_d", pc_d, 32'h300);
        chk("t4b_inst", inst_d, 32'h1234_0300);
        chk("t4b_addr", imem_addr, 32'h304);
        // T5 wrap at top of address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t5_addr0", imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("t5_addr1", imem_addr, 32'h0);
        chk("t5_pc_d1", pc_d, 32'hFFFF_FFFC);
        chk("t5_pc4", pc_plus4_d, 32'h0);
        chk("t5_inst1", inst_d, 32'hEDCB_FFFC);
        @(negedge clk);
        chk("t5_addr2", imem_addr, 32'h4);
        chk("t5_pc_d2", pc_d, 32'h0);
        chk("t5_valid2", 32'(valid_d), 1);
        chk("t5_inst2", inst_d, 32'h1234_0000);
        // T6 reset while in STALL
        fetch_stall = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(valid_d), 0);
        chk("t6_pc_d", pc_d, 32'h0);
        chk("t6_rden", 32'(imem_rd_en), 0);
        chk("t6_addr", imem_addr, 32'h100);
        chk("t6_inst", inst_d, NOP);
        reset = 1'b1; fetch_stall = 1'b0;
        #1;
        chk("t6_boot_valid", 32'(valid_d), 0);
        @(negedge clk);
        chk("t6_rb_pc_d", pc_d, 32'h100);
        chk("t6_rb_valid", 32'(valid_d), 1);
        chk("t6_rb_inst", inst_d, 32'h1234_0100);
        chk("t6_rb_addr", imem_addr, 32'h104);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
